// File: rtl/bus_owner_ctrl_pkg.sv
// Shared definitions for the bus ownership controller: requester count,
// counter width, default timeout and the state / grant-class enums.
package bus_owner_ctrl_pkg;

    localparam int NUM_REQ        = 4;
    localparam int CNT_W          = 8;
    localparam int TMO_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        OWN,
        RELEASE,
        SETTLE
    } state_t;

    typedef enum logic [1:0] {
        GNT_ZERO,
        GNT_ONE,
        GNT_MULTI
    } gnt_class_t;

endpackage

// File: rtl/bus_owner_ctrl_onehot_chk.sv
// Combinational classifier for the grant vector: zero, one-hot or multi-hot.
module onehot_chk
    import bus_owner_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output gnt_class_t         cls
);

    logic [NUM_REQ-1:0] low_cleared;

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set
    always_comb begin
        low_cleared = vec & (vec - NUM_REQ'(1));
        cls         = GNT_ZERO;
        if (vec == '0) begin
            cls = GNT_ZERO;
        end else if (low_cleared == '0) begin
            cls = GNT_ONE;
        end else begin
            cls = GNT_MULTI;
        end
    end

endmodule

// File: rtl/bus_owner_ctrl.sv
// Bus ownership controller: accepts a grant from the upstream resolver,
// holds ownership until release, requester drop or timeout, then enforces
// a two-cycle turnaround before arbitration may advance again.
module bus_owner_ctrl
    import bus_owner_ctrl_pkg::*;
#(
    parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] gnt,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic               pr_en,
    output logic [NUM_REQ-1:0] owner,
    output logic [NUM_REQ-1:0] ack,
    output logic               busy,
    output logic               tmo,
    output logic               err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state;
    gnt_class_t         gnt_class;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               rel_hit;
    logic               req_drop;

    onehot_chk u_onehot_chk (
        .vec (gnt),
        .cls (gnt_class)
    );

    // Ownership counter step (saturating) and the two voluntary release causes
    always_comb begin
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        rel_hit  = (rel & owner) != '0;
        req_drop = (req & owner) == '0;
    end

    // Ownership FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            ack   <= '0;
            busy  <= 1'b0;
            tmo   <= 1'b0;
            err   <= 1'b0;
            pr_en <= 1'b0;
            cnt   <= '0;
        end else begin
            ack <= '0;
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    pr_en <= 1'b1;
                    busy  <= 1'b0;
                    owner <= '0;
                    case (gnt_class)
                        GNT_ONE: begin
                            if ((gnt & req) != '0) begin
                                state <= GRANT;
                                owner <= gnt;
                                ack   <= gnt;
                                busy  <= 1'b1;
                                pr_en <= 1'b0;
                                cnt   <= '0;
                            end
                        end
                        GNT_MULTI: err <= 1'b1;
                        default: ;
                    endcase
                end
                GRANT: begin
                    state <= OWN;
                    cnt   <= cnt_next;
                end
                OWN: begin
                    if (rel_hit || req_drop) begin
                        state <= RELEASE;
                        owner <= '0;
                        busy  <= 1'b0;
                        pr_en <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        state <= RELEASE;
                        owner <= '0;
                        busy  <= 1'b0;
                        pr_en <= 1'b1;
                        tmo   <= 1'b1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                RELEASE: begin
                    state <= SETTLE;
                    pr_en <= 1'b1;
                end
                SETTLE: begin
                    state <= IDLE;
                    pr_en <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    owner <= '0;
                    busy  <= 1'b0;
                    pr_en <= 1'b1;
                end
            endcase
        end
    end

endmodule
